// File: rtl/iter_adder_2b_pkg.sv
// Shared definitions for the iterative 2-bit-per-cycle adder.
// Contents: FSM state encoding used by iter_adder_2b.
package iter_adder_2b_pkg;

    typedef enum logic [1:0] {
        STATE_IDLE = 2'd0,
        STATE_CALC = 2'd1,
        STATE_DONE = 2'd2
    } state_e;

endpackage

// File: rtl/add_slice_2b.sv
// Purely combinational 2-bit full adder slice.
// Ports:
//   a0[1:0], b0[1:0] : operand bit pairs
//   cin              : carry in
//   sum[1:0]         : sum bits
//   cout             : carry out
module add_slice_2b (
    input  logic [1:0] a0,
    input  logic [1:0] b0,
    input  logic       cin,
    output logic [1:0] sum,
    output logic       cout
);

    logic [2:0] total;

    always_comb begin
        total = {1'b0, a0} + {1'b0, b0} + {2'b00, cin};
        sum   = total[1:0];
        cout  = total[2];
    end

endmodule

// File: rtl/iter_adder_2b.sv
// Multi-cycle NBITS-wide adder that reuses one 2-bit adder slice, holding
// the carry in a register between cycles. Val/rdy handshakes on both sides.
// Ports:
//   clk, rst                 : clock, synchronous active-high reset
//   istream_val/istream_rdy  : operand handshake (in0, in1)
//   ostream_val/ostream_rdy  : result handshake (out, cout)
//   out                      : (in0 + in1) mod 2^NBITS
//   cout                     : carry-out of the full addition
module iter_adder_2b
    import iter_adder_2b_pkg::*;
#(
    parameter int unsigned NBITS = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             istream_val,
    output logic             istream_rdy,
    input  logic [NBITS-1:0] in0,
    input  logic [NBITS-1:0] in1,
    output logic             ostream_val,
    input  logic             ostream_rdy,
    output logic [NBITS-1:0] out,
    output logic             cout
);

    localparam int unsigned STEPS = NBITS / 2;
    localparam int unsigned CW    = $clog2(STEPS) + 1;
    localparam logic [CW-1:0] LAST_STEP = CW'(STEPS - 1);

    state_e           state_q, state_d;
    logic [NBITS-1:0] a_q, a_d;
    logic [NBITS-1:0] b_q, b_d;
    logic [NBITS-1:0] result_q, result_d;
    logic             carry_q, carry_d;
    logic             cout_q, cout_d;
    logic [CW-1:0]    cnt_q, cnt_d;

    logic [1:0]       slice_sum;
    logic             slice_cout;

    add_slice_2b u_slice (
        .a0   (a_q[1:0]),
        .b0   (b_q[1:0]),
        .cin  (carry_q),
        .sum  (slice_sum),
        .cout (slice_cout)
    );

    // rst gates both handshake outputs so nothing is offered or presented
    // while a reset is being applied, including a reset landing in DONE.
    assign istream_rdy = (state_q == STATE_IDLE) && !rst;
    assign ostream_val = (state_q == STATE_DONE) && !rst;
    assign out         = result_q;
    assign cout        = cout_q;

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        result_d = result_q;
        carry_d  = carry_q;
        cout_d   = cout_q;
        cnt_d    = cnt_q;

        unique case (state_q)
            STATE_IDLE: begin
                if (istream_val && istream_rdy) begin
                    a_d     = in0;
                    b_d     = in1;
                    carry_d = 1'b0;
                    cnt_d   = '0;
                    state_d = STATE_CALC;
                end
            end
            STATE_CALC: begin
                // Operands drain LSB-first; the sum fills in from the MSB end
                // so after STEPS shifts it sits fully aligned.
                a_d      = {2'b00, a_q[NBITS-1:2]};
                b_d      = {2'b00, b_q[NBITS-1:2]};
                result_d = {slice_sum, result_q[NBITS-1:2]};
                carry_d  = slice_cout;
                cnt_d    = cnt_q + CW'(1);
                if (cnt_q == LAST_STEP) begin
                    cout_d  = slice_cout;
                    state_d = STATE_DONE;
                end
            end
            STATE_DONE: begin
                if (ostream_rdy) begin
                    state_d = STATE_IDLE;
                end
            end
            default: begin
                state_d = STATE_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= STATE_IDLE;
            a_q      <= '0;
            b_q      <= '0;
            result_q <= '0;
            carry_q  <= 1'b0;
            cout_q   <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            result_q <= result_d;
            carry_q  <= carry_d;
            cout_q   <= cout_d;
            cnt_q    <= cnt_d;
        end
    end

endmodule

// File: tb/tb_iter_adder_2b.sv
// Self-checking bench for iter_adder_2b (NBITS=8): directed cases plus
// randomized operands against a plain-arithmetic reference.
module tb_iter_adder_2b;

    localparam int unsigned NB    = 8;
    localparam int unsigned STEPS = NB / 2;

    logic          clk;
    logic          rst;
    logic          istream_val;
    logic          istream_rdy;
    logic [NB-1:0] in0;
    logic [NB-1:0] in1;
    logic          ostream_val;
    logic          ostream_rdy;
    logic [NB-1:0] dut_out;
    logic          dut_cout;

    int unsigned n_vectors     = 0;
    int unsigned n_miscompares = 0;
    logic [NB:0] exp_sum;

    iter_adder_2b #(.NBITS(NB)) dut (
        .clk         (clk),
        .rst         (rst),
        .istream_val (istream_val),
        .istream_rdy (istream_rdy),
        .in0         (in0),
        .in1         (in1),
        .ostream_val (ostream_val),
        .ostream_rdy (ostream_rdy),
        .out         (dut_out),
        .cout        (dut_cout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got,
                             input logic [31:0] exp);
        n_vectors++;
        if (got !== exp) begin
            n_miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Present operands, wait (bounded) for acceptance; returns at the
    // negedge following the accepting edge.
    task automatic send_ops(input logic [NB-1:0] a, input logic [NB-1:0] b,
                            input bit keep_val);
        int unsigned waitc = 0;
        in0 = a;
        in1 = b;
        istream_val = 1'b1;
        while (!istream_rdy && waitc < 50) begin
            @(negedge clk);
            waitc++;
        end
        check_val("accept_rdy", istream_rdy, 1);
        exp_sum = {1'b0, a} + {1'b0, b};
        @(posedge clk);
        @(negedge clk);
        if (!keep_val) istream_val = 1'b0;
    endtask

    // Wait for the result, check latency/value, apply optional backpressure
    // and confirm the return to IDLE.
    task automatic collect(input int unsigned hold, input bit rnd_rdy);
        int unsigned lat = 0;
        while (!ostream_val && lat < 20) begin
            check_val("calc_irdy", istream_rdy, 0);
            if (rnd_rdy) ostream_rdy = 1'($urandom_range(0, 1));
            @(negedge clk);
            lat++;
        end
        check_val("latency", lat, STEPS);
        if (!ostream_val) return;
        check_val("out", dut_out, exp_sum[NB-1:0]);
        check_val("cout", dut_cout, exp_sum[NB]);
        check_val("done_irdy", istream_rdy, 0);
        if (hold > 0) begin
            ostream_rdy = 1'b0;
            for (int unsigned i = 0; i < hold; i++) begin
                @(negedge clk);
                check_val("bp_val", ostream_val, 1);
                check_val("bp_result", {dut_cout, dut_out}, exp_sum);
                check_val("bp_irdy", istream_rdy, 0);
            end
        end
        ostream_rdy = 1'b1;
        @(negedge clk);
        check_val("ret_val", ostream_val, 0);
        check_val("ret_irdy", istream_rdy, 1);
        check_val("hold_last", {dut_cout, dut_out}, exp_sum);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned waitc;
        rst = 1'b1;
        istream_val = 1'b0;
        ostream_rdy = 1'b0;
        in0 = '0;
        in1 = '0;
        exp_sum = '0;

        // Reset for two cycles.
        @(negedge clk);
        check_val("rst_irdy", istream_rdy, 0);
        check_val("rst_oval", ostream_val, 0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check_val("post_rst_irdy", istream_rdy, 1);
        check_val("post_rst_oval", ostream_val, 0);
        check_val("post_rst_result", {dut_cout, dut_out}, 0);
        @(negedge clk);

        // Basic add, with ostream_rdy already high.
        ostream_rdy = 1'b1;
        send_ops(8'h03, 8'h05, 1'b0);
        collect(0, 1'b0);

        // Overflow and complementary patterns, zero operands.
        send_ops(8'hFF, 8'h01, 1'b0);
        collect(0, 1'b0);
        send_ops(8'hAA, 8'h55, 1'b0);
        collect(0, 1'b0);
        send_ops(8'h00, 8'h00, 1'b0);
        collect(0, 1'b0);

        // Backpressure for three cycles in DONE.
        send_ops(8'h7F, 8'h7F, 1'b0);
        collect(3, 1'b0);

        // Back-to-back with istream_val held high throughout.
        send_ops(8'h01, 8'h01, 1'b1);
        collect(0, 1'b0);
        send_ops(8'h80, 8'h80, 1'b1);
        collect(1, 1'b0);
        send_ops(8'h10, 8'h0F, 1'b0);
        collect(0, 1'b0);

        // Reset two cycles into CALC.
        send_ops(8'h12, 8'h34, 1'b0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check_val("calc_rst_irdy", istream_rdy, 0);
        check_val("calc_rst_oval", ostream_val, 0);
        repeat (2) begin
            @(negedge clk);
            check_val("calc_rst_hold_oval", ostream_val, 0);
        end
        rst = 1'b0;
        #1;
        check_val("calc_rst_release_irdy", istream_rdy, 1);
        repeat (6) begin
            @(negedge clk);
            check_val("calc_rst_no_result", ostream_val, 0);
        end
        send_ops(8'h22, 8'h11, 1'b0);
        collect(0, 1'b0);

        // Reset in DONE, coinciding with ostream_rdy.
        send_ops(8'h40, 8'h41, 1'b0);
        waitc = 0;
        while (!ostream_val && waitc < 20) begin
            @(negedge clk);
            waitc++;
        end
        check_val("done_reached", ostream_val, 1);
        ostream_rdy = 1'b1;
        rst = 1'b1;
        #1;
        check_val("done_rst_oval", ostream_val, 0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check_val("done_rst_irdy", istream_rdy, 1);
        check_val("done_rst_oval2", ostream_val, 0);
        check_val("done_rst_cleared", {dut_cout, dut_out}, 0);
        @(negedge clk);

        // Randomized operands with random ready behaviour and idle gaps.
        for (int unsigned t = 0; t < 200; t++) begin
            logic [NB-1:0] ra, rb;
            ra = NB'($urandom);
            rb = NB'($urandom);
            send_ops(ra, rb, 1'b0);
            collect($urandom_range(0, 3), 1'b1);
            repeat ($urandom_range(0, 2)) begin
                ostream_rdy = 1'($urandom_range(0, 1));
                @(negedge clk);
                check_val("idle_oval", ostream_val, 0);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
        $finish;
    end

endmodule
